// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard/stall controller for the 5-stage RV64 pipeline. Merges load-use detection,
// branch-redirect flushing and multi-cycle data-memory waits into the hold/flush controls of
// the PC, IF/ID, ID/EX and EX/MEM registers, and keeps saturating stall/flush counters.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   i_id_rs1, i_id_rs2      : source registers of the instruction in ID
//   i_ex_memread, i_ex_rd   : ID/EX memread and destination register
//   i_mem_branch, i_mem_zero: EX/MEM branch and ALU-zero
//   i_mem_memread/_memwrite : EX/MEM data-memory access controls
//   i_dmem_ready            : data memory completes the current access this cycle
//   o_pc_write, o_pc_src    : PC load enable, select branch target
//   o_ifid_write            : IF/ID load enable
//   o_*_flush               : clear IF/ID, ID/EX, EX/MEM to bubble on the next edge
//   o_idex_bubble           : load a NOP into ID/EX
//   o_exmem_hold            : EX/MEM and ID/EX retain their contents
//   o_memwb_bubble          : load a bubble into MEM/WB
//   o_dmem_req              : data-memory request
//   o_mem_err               : sticky memory-wait timeout flag
//   o_stall_cnt, o_flush_cnt: saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_mem_branch,
  input  logic             i_mem_zero,
  input  logic             i_mem_memread,
  input  logic             i_mem_memwrite,
  input  logic             i_dmem_ready,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_idex_bubble,
  output logic             o_exmem_hold,
  output logic             o_memwb_bubble,
  output logic             o_dmem_req,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned TmrW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(MEM_TIMEOUT - 1);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [TmrW-1:0]   r_timer;
  logic [TmrW-1:0]   w_timer_next;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_branch;
  logic w_load_use;
  logic w_mem_access;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_set_err;

  assign w_branch     = i_mem_branch & i_mem_zero;
  assign w_load_use   = i_ex_memread & (i_ex_rd != 5'd0) &
                        ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));
  assign w_mem_access = i_mem_memread | i_mem_memwrite;

  always_comb begin
    o_pc_write     = 1'b0;
    o_pc_src       = 1'b0;
    o_ifid_write   = 1'b0;
    o_ifid_flush   = 1'b0;
    o_idex_flush   = 1'b0;
    o_exmem_flush  = 1'b0;
    o_idex_bubble  = 1'b0;
    o_exmem_hold   = 1'b0;
    o_memwb_bubble = 1'b0;
    o_dmem_req     = 1'b0;
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    w_set_err      = 1'b0;

    if (!rst_n) begin
      // Outputs follow reset combinationally so a reset mid-wait drops the request at once.
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
      w_state_next  = StRun;
    end else begin
      case (r_state)
        StRun: begin
          if (w_branch) begin
            // Redirect wins over everything; load-use and memory access are ignored.
            o_pc_src      = 1'b1;
            o_pc_write    = 1'b1;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
            w_flush_inc   = 1'b1;
          end else if (w_mem_access && !i_dmem_ready) begin
            // Freeze starts in the entry cycle, not one cycle late.
            o_dmem_req     = 1'b1;
            o_exmem_hold   = 1'b1;
            o_memwb_bubble = 1'b1;
            w_stall_inc    = 1'b1;
            w_state_next   = StMemWait;
            w_timer_next   = '0;
          end else begin
            o_dmem_req = w_mem_access;
            if (w_load_use) begin
              o_idex_bubble = 1'b1;
              w_stall_inc   = 1'b1;
            end else begin
              o_pc_write   = 1'b1;
              o_ifid_write = 1'b1;
            end
          end
        end
        StMemWait: begin
          o_dmem_req     = 1'b1;
          o_exmem_hold   = 1'b1;
          o_memwb_bubble = 1'b1;
          w_stall_inc    = 1'b1;
          if (i_dmem_ready) begin
            w_state_next = StRun;
          end else if (r_timer == TmrLast) begin
            // Abort the access: flag the error and drop the stuck EX/MEM entry.
            o_exmem_flush = 1'b1;
            w_set_err     = 1'b1;
            w_state_next  = StRun;
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
        default: w_state_next = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_timer     <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      if (w_set_err) begin
        r_mem_err <= 1'b1;
      end
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_inc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign o_mem_err   = r_mem_err;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and stall controller for the 5-stage RV64 pipeline. Combines load-use detection, branch-redirect flushing and multi-cycle data-memory wait handling into the write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It also keeps saturating stall and flush counters for performance debug. The block sits beside the pipeline registers and is their only source of flush and hold controls.

## Interface
- `MEM_TIMEOUT`, default 64: maximum number of cycles spent in MEM_WAIT before the wait is aborted.
- `CNT_W`, default 16: width of each performance counter.
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `ex_memread` in 1, `ex_rd` in 5: ID/EX memread and rd.
- `mem_branch`, `mem_zero` in 1 each: EX/MEM Branch and zero.
- `mem_memread`, `mem_memwrite` in 1 each: EX/MEM memory-access controls.
- `dmem_ready` in 1: data memory completes the current access this cycle.
- `pc_write` out 1: PC load enable.
- `pc_src` out 1: select branch target (EX/MEM Adderout).
- `ifid_write` out 1: IF/ID load enable.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: clear the register to its bubble value on the next edge.
- `idex_bubble` out 1: load a NOP (all controls 0) into ID/EX.
- `exmem_hold` out 1: EX/MEM and ID/EX retain their current contents.
- `memwb_bubble` out 1: load a bubble into MEM/WB.
- `dmem_req` out 1: data-memory request.
- `mem_err` out 1: sticky flag, set when a memory wait times out.
- `stall_cnt`, `flush_cnt` out CNT_W each: saturating performance counters.

## Operation
- FSM with two states, RUN and MEM_WAIT. The state is reset to RUN.
- Branch taken means `mem_branch & mem_zero`. Load-use hazard means `ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2)`. Memory access means `mem_memread | mem_memwrite`.
- RUN, priority high to low:
  1. Branch taken: `pc_src=1`, `pc_write=1`, `ifid_flush=idex_flush=exmem_flush=1`. Load-use is ignored. `flush_cnt` increments.
  2. Memory access with `dmem_ready=0`: `dmem_req=1`, go to MEM_WAIT, and apply the freeze outputs in this same cycle. `stall_cnt` increments.
  3. Load-use: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`. `stall_cnt` increments.
  4. Otherwise: `pc_write=1`, `ifid_write=1`. All other outputs are 0.
- A memory access that sees `dmem_ready=1` in RUN finishes in a single cycle with no stall. `dmem_req=1` for that cycle. Rule 3 or 4 applies in parallel.
- Branch and memory access are mutually exclusive in EX/MEM. If both are seen, the branch wins and `dmem_req=0`.
- MEM_WAIT freeze outputs: `dmem_req=1`, `pc_write=0`, `ifid_write=0`, `exmem_hold=1`, `memwb_bubble=1`. Branch and load-use are not evaluated in this state. `stall_cnt` increments every cycle.
- Leaving MEM_WAIT: when `dmem_ready=1`, return to RUN. The freeze outputs are still driven in that cycle, so the pipeline advances on the edge after.
- Wait timer: a cycle counter is cleared on entry to MEM_WAIT. When it reaches `MEM_TIMEOUT-1` with `dmem_ready=0`, `mem_err` is set, the FSM returns to RUN, and `exmem_flush=1` drops the access.
- `mem_err` clears only on reset.
- Counters saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the state and the inputs, with zero latency. The state, wait timer, counters and `mem_err` are registered.
- While `reset=0`: state is RUN, `stall_cnt=flush_cnt=0`, `mem_err=0`. All enables and `dmem_req` are 0. `ifid_flush`, `idex_flush` and `exmem_flush` are 1.
- Reset asserted mid-MEM_WAIT forces RUN immediately and drops `dmem_req` in the same cycle.
- Minimum MEM_WAIT residency is 1 cycle. Maximum is `MEM_TIMEOUT` cycles.
- A load-use stall lasts exactly 1 cycle, because the bubble clears `ex_memread`.
- Branch penalty is 3 flushed slots, with no extra stall cycle.

## Test plan
- Reset, then release: all counters 0, `mem_err=0`. In the first RUN cycle with no hazards, `pc_write=ifid_write=1`.
- `ex_memread=1`, `ex_rd=5`, `id_rs2=5` for one cycle: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `stall_cnt` goes to 1. Repeat with `ex_rd=0`: no stall.
- `mem_branch=1`, `mem_zero=1`, with a load-use hazard also present: `pc_src=1`, all three flushes 1, `idex_bubble=0`, `flush_cnt=1`.
- `mem_memread=1` with `dmem_ready` low for 3 cycles, then high: MEM_WAIT held for 4 cycles with `exmem_hold=1`, `memwb_bubble=1` and `dmem_req=1` throughout. `stall_cnt=4`, then the FSM is back in RUN.
- `MEM_TIMEOUT=4`, `mem_memwrite=1`, `dmem_ready` never asserted: `mem_err` rises after 4 cycles, `exmem_flush=1`, FSM is in RUN. `mem_err` stays 1 until reset.
- `CNT_W=4`: 20 consecutive load-use stalls leave `stall_cnt` at 15. Asserting reset during MEM_WAIT clears the state and `dmem_req` asynchronously.
